// File: rtl/altpcie_av_cfg_pkg.sv
// Shared definitions for the HIP configuration-bus sampler.
// Holds the tl_cfg_add slot numbers, the bit positions of the decoded
// fields within each 32-bit tl_cfg_ctl word, and the capture FSM states.
package altpcie_av_cfg_pkg;

  // tl_cfg_add slots that carry decoded fields
  localparam logic [3:0] CFG_ADD_DEVCTRL    = 4'h0;
  localparam logic [3:0] CFG_ADD_LINKCTRL   = 4'h2;
  localparam logic [3:0] CFG_ADD_CMD        = 4'h3;
  localparam logic [3:0] CFG_ADD_MSIADDR_LO = 4'hC;
  localparam logic [3:0] CFG_ADD_MSIADDR_HI = 4'hD;
  localparam logic [3:0] CFG_ADD_MSIDATA    = 4'hE;
  localparam logic [3:0] CFG_ADD_BUSDEV     = 4'hF;

  // Field positions inside the tl_cfg_ctl word of the owning slot
  localparam int unsigned DEVCTRL_MSB  = 31;
  localparam int unsigned DEVCTRL_LSB  = 16;
  localparam int unsigned LINKCTRL_MSB = 31;
  localparam int unsigned LINKCTRL_LSB = 16;
  localparam int unsigned CMD_MSB      = 23;
  localparam int unsigned CMD_LSB      = 8;
  localparam int unsigned MSIDATA_MSB  = 15;
  localparam int unsigned MSIDATA_LSB  = 0;
  localparam int unsigned BUSDEV_MSB   = 12;
  localparam int unsigned BUSDEV_LSB   = 0;

  // Sub-fields of the Device Control register
  localparam int unsigned MAX_PAYLOAD_MSB = 7;
  localparam int unsigned MAX_PAYLOAD_LSB = 5;
  localparam int unsigned MAX_RD_REQ_MSB  = 14;
  localparam int unsigned MAX_RD_REQ_LSB  = 12;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2
  } cfg_state_e;

endpackage

// File: rtl/altpcie_av_toggle_detect.sv
// Strobe toggle detector.
// Registers a level strobe once and flags any cycle where the live strobe
// differs from its registered copy.
//   clk    : clock
//   rst    : asynchronous active-high reset (history clears to 0)
//   strobe : toggling write strobe from the HIP
//   tog    : high while strobe differs from its previous-cycle value
module altpcie_av_toggle_detect (
  input  logic clk,
  input  logic rst,
  input  logic strobe,
  output logic tog
);

  logic strobe_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      strobe_q <= 1'b0;
    end else begin
      strobe_q <= strobe;
    end
  end

  assign tog = strobe ^ strobe_q;

endmodule

// File: rtl/altpcie_av_tl_cfg_sampler.sv
// Application-side receiver for the HIP time-multiplexed configuration bus.
// A ctl_wr toggle starts a settle window; once tl_cfg_add/ctl have been
// stable for SETTLE_CYCLES the word is written into a 16-entry shadow and
// decoded fields are presented combinationally from the shadow. Status words
// are captured on every sts_wr toggle with no settle delay.
// Ports:
//   pld_clk, reset          : clock, asynchronous active-high reset
//   tl_cfg_add/ctl/ctl_wr   : multiplexed control bus and its toggle strobe
//   tl_cfg_sts/sts_wr       : status word and its toggle strobe
//   cfg_busdev .. cfg_msi_* : decoded configuration fields
//   cfg_sts                 : last captured status word
//   cfg_update/_add         : one-cycle capture pulse and its address
//   cfg_seen, cfg_ready     : per-address captured flags, required set seen
module altpcie_av_tl_cfg_sampler
  import altpcie_av_cfg_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 3,
  parameter logic [15:0] REQUIRED_MASK = 16'h800D
) (
  input  logic        pld_clk,
  input  logic        reset,
  input  logic [3:0]  tl_cfg_add,
  input  logic [31:0] tl_cfg_ctl,
  input  logic        tl_cfg_ctl_wr,
  input  logic [52:0] tl_cfg_sts,
  input  logic        tl_cfg_sts_wr,
  output logic [12:0] cfg_busdev,
  output logic [15:0] cfg_dev_ctrl,
  output logic [2:0]  cfg_max_payload,
  output logic [2:0]  cfg_max_rd_req,
  output logic [15:0] cfg_link_ctrl,
  output logic [15:0] cfg_prm_cmd,
  output logic [63:0] cfg_msi_addr,
  output logic [15:0] cfg_msi_data,
  output logic [52:0] cfg_sts,
  output logic        cfg_update,
  output logic [3:0]  cfg_update_add,
  output logic [15:0] cfg_seen,
  output logic        cfg_ready
);

  localparam logic [2:0] SettleLoad = 3'(SETTLE_CYCLES - 1);

  logic ctl_tog;
  logic sts_tog;

  altpcie_av_toggle_detect u_ctl_tog (
    .clk    (pld_clk),
    .rst    (reset),
    .strobe (tl_cfg_ctl_wr),
    .tog    (ctl_tog)
  );

  altpcie_av_toggle_detect u_sts_tog (
    .clk    (pld_clk),
    .rst    (reset),
    .strobe (tl_cfg_sts_wr),
    .tog    (sts_tog)
  );

  // Capture FSM
  cfg_state_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       capture;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ctl_tog) begin
          state_d = SETTLE;
          cnt_d   = SettleLoad;
        end
      end
      SETTLE: begin
        // A fresh toggle means the bus moved again: restart the window
        if (ctl_tog) begin
          cnt_d = SettleLoad;
        end else if (cnt_q == 3'd0) begin
          state_d = CAPTURE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      CAPTURE: begin
        capture = 1'b1;
        // Toggle landing on the capture cycle must start a new window
        if (ctl_tog) begin
          state_d = SETTLE;
          cnt_d   = SettleLoad;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge pld_clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Shadow, capture flags and registered pulse
  logic [31:0] shadow_q [16];
  logic [15:0] seen_q;
  logic        update_q;
  logic [3:0]  update_add_q;
  logic        ready_q;
  logic [52:0] sts_q;

  always_ff @(posedge pld_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        shadow_q[i] <= 32'h0;
      end
      seen_q       <= 16'h0;
      update_q     <= 1'b0;
      update_add_q <= 4'h0;
    end else begin
      update_q <= capture;
      if (capture) begin
        shadow_q[tl_cfg_add] <= tl_cfg_ctl;
        seen_q[tl_cfg_add]   <= 1'b1;
        update_add_q         <= tl_cfg_add;
      end
    end
  end

  // Sticky: a rewrite of an already-seen address never drops ready
  always_ff @(posedge pld_clk or posedge reset) begin
    if (reset) begin
      ready_q <= 1'b0;
    end else if ((seen_q & REQUIRED_MASK) == REQUIRED_MASK) begin
      ready_q <= 1'b1;
    end
  end

  always_ff @(posedge pld_clk or posedge reset) begin
    if (reset) begin
      sts_q <= 53'h0;
    end else if (sts_tog) begin
      sts_q <= tl_cfg_sts;
    end
  end

  // Decode
  assign cfg_dev_ctrl    = shadow_q[CFG_ADD_DEVCTRL][DEVCTRL_MSB:DEVCTRL_LSB];
  assign cfg_max_payload = cfg_dev_ctrl[MAX_PAYLOAD_MSB:MAX_PAYLOAD_LSB];
  assign cfg_max_rd_req  = cfg_dev_ctrl[MAX_RD_REQ_MSB:MAX_RD_REQ_LSB];
  assign cfg_link_ctrl   = shadow_q[CFG_ADD_LINKCTRL][LINKCTRL_MSB:LINKCTRL_LSB];
  assign cfg_prm_cmd     = shadow_q[CFG_ADD_CMD][CMD_MSB:CMD_LSB];
  assign cfg_msi_addr    = {shadow_q[CFG_ADD_MSIADDR_HI], shadow_q[CFG_ADD_MSIADDR_LO]};
  assign cfg_msi_data    = shadow_q[CFG_ADD_MSIDATA][MSIDATA_MSB:MSIDATA_LSB];
  assign cfg_busdev      = shadow_q[CFG_ADD_BUSDEV][BUSDEV_MSB:BUSDEV_LSB];

  assign cfg_sts        = sts_q;
  assign cfg_update     = update_q;
  assign cfg_update_add = update_add_q;
  assign cfg_seen       = seen_q;
  assign cfg_ready      = ready_q;

  // Slots and bit ranges that are stored but not decoded
  logic unused_shadow;
  assign unused_shadow = ^{shadow_q[1], shadow_q[4], shadow_q[5], shadow_q[6], shadow_q[7],
                           shadow_q[8], shadow_q[9], shadow_q[10], shadow_q[11],
                           shadow_q[0][15:0], shadow_q[2][15:0],
                           shadow_q[3][31:24], shadow_q[3][7:0],
                           shadow_q[14][31:16], shadow_q[15][31:13]};

endmodule

// File: tb/tb_altpcie_av_tl_cfg_sampler.sv
// Scoreboard bench for altpcie_av_tl_cfg_sampler.
// Stimulus pushes expected captures (address, word, due cycle) into queues;
// a negedge monitor pops them when the DUT pulses cfg_update or changes
// cfg_sts and compares against a shadow-array model of the decoded fields.
module tb_altpcie_av_tl_cfg_sampler;

  localparam logic [15:0] ReqMask = 16'h800D;

  logic        pld_clk = 1'b0;
  logic        reset   = 1'b1;
  logic [3:0]  tl_cfg_add = 4'h0;
  logic [31:0] tl_cfg_ctl = 32'h0;
  logic        tl_cfg_ctl_wr = 1'b0;
  logic [52:0] tl_cfg_sts = 53'h0;
  logic        tl_cfg_sts_wr = 1'b0;
  logic [12:0] cfg_busdev;
  logic [15:0] cfg_dev_ctrl;
  logic [2:0]  cfg_max_payload;
  logic [2:0]  cfg_max_rd_req;
  logic [15:0] cfg_link_ctrl;
  logic [15:0] cfg_prm_cmd;
  logic [63:0] cfg_msi_addr;
  logic [15:0] cfg_msi_data;
  logic [52:0] cfg_sts;
  logic        cfg_update;
  logic [3:0]  cfg_update_add;
  logic [15:0] cfg_seen;
  logic        cfg_ready;

  altpcie_av_tl_cfg_sampler dut (
    .pld_clk         (pld_clk),
    .reset           (reset),
    .tl_cfg_add      (tl_cfg_add),
    .tl_cfg_ctl      (tl_cfg_ctl),
    .tl_cfg_ctl_wr   (tl_cfg_ctl_wr),
    .tl_cfg_sts      (tl_cfg_sts),
    .tl_cfg_sts_wr   (tl_cfg_sts_wr),
    .cfg_busdev      (cfg_busdev),
    .cfg_dev_ctrl    (cfg_dev_ctrl),
    .cfg_max_payload (cfg_max_payload),
    .cfg_max_rd_req  (cfg_max_rd_req),
    .cfg_link_ctrl   (cfg_link_ctrl),
    .cfg_prm_cmd     (cfg_prm_cmd),
    .cfg_msi_addr    (cfg_msi_addr),
    .cfg_msi_data    (cfg_msi_data),
    .cfg_sts         (cfg_sts),
    .cfg_update      (cfg_update),
    .cfg_update_add  (cfg_update_add),
    .cfg_seen        (cfg_seen),
    .cfg_ready       (cfg_ready)
  );

  always #5 pld_clk = ~pld_clk;

  int cyc = 0;
  always @(posedge pld_clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [3:0]  add;
    logic [31:0] ctl;
  } ctl_exp_t;

  typedef struct {
    int          due;
    logic [52:0] sts;
  } sts_exp_t;

  ctl_exp_t ctl_q[$];
  sts_exp_t sts_q[$];

  int checks = 0;
  int errors = 0;
  int last_ctl_tog = -100;
  logic [52:0] last_sts_exp = 53'h0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a capture lands 5 cycles after its toggle unless another toggle
  // follows within 3 cycles; decoded fields are slices of the latest word per address.
  logic [31:0] m_shadow [16];
  logic [15:0] m_seen = 16'h0;
  bit          m_ready = 1'b0;
  logic [52:0] prev_sts = 53'h0;

  always @(negedge pld_clk) begin
    if (reset) begin
      chk("reset_outputs_zero", 128'(|{cfg_busdev, cfg_dev_ctrl, cfg_max_payload,
          cfg_max_rd_req, cfg_link_ctrl, cfg_prm_cmd, cfg_msi_addr, cfg_msi_data, cfg_sts,
          cfg_update, cfg_update_add, cfg_seen, cfg_ready}), 128'd0);
      for (int i = 0; i < 16; i++) m_shadow[i] = 32'h0;
      m_seen   = 16'h0;
      m_ready  = 1'b0;
      prev_sts = 53'h0;
    end else begin
      chk("cfg_ready", cfg_ready, m_ready);
      if (cfg_update) begin
        if (ctl_q.size() == 0) begin
          chk("unexpected_cfg_update", 1, 0);
        end else begin
          ctl_exp_t e;
          e = ctl_q.pop_front();
          chk("update_cycle", cyc, e.due);
          chk("cfg_update_add", cfg_update_add, e.add);
          m_shadow[e.add] = e.ctl;
          m_seen[e.add]   = 1'b1;
        end
      end
      while (ctl_q.size() > 0 && ctl_q[0].due < cyc) begin
        chk("missing_ctl_capture_due", cyc, ctl_q[0].due);
        void'(ctl_q.pop_front());
      end
      chk("cfg_seen", cfg_seen, m_seen);
      chk("cfg_dev_ctrl", cfg_dev_ctrl, m_shadow[0][31:16]);
      chk("cfg_max_payload", cfg_max_payload, m_shadow[0][23:21]);
      chk("cfg_max_rd_req", cfg_max_rd_req, m_shadow[0][30:28]);
      chk("cfg_link_ctrl", cfg_link_ctrl, m_shadow[2][31:16]);
      chk("cfg_prm_cmd", cfg_prm_cmd, m_shadow[3][23:8]);
      chk("cfg_msi_addr", cfg_msi_addr, {m_shadow[13], m_shadow[12]});
      chk("cfg_msi_data", cfg_msi_data, m_shadow[14][15:0]);
      chk("cfg_busdev", cfg_busdev, m_shadow[15][12:0]);
      if (cfg_sts !== prev_sts) begin
        if (sts_q.size() == 0) begin
          chk("unexpected_cfg_sts_change", 1, 0);
        end else begin
          sts_exp_t s;
          s = sts_q.pop_front();
          chk("cfg_sts_value", cfg_sts, s.sts);
          chk("cfg_sts_cycle", cyc, s.due);
        end
        prev_sts = cfg_sts;
      end
      while (sts_q.size() > 0 && sts_q[0].due < cyc) begin
        chk("missing_sts_capture_due", cyc, sts_q[0].due);
        void'(sts_q.pop_front());
      end
      if ((m_seen & ReqMask) == ReqMask) m_ready = 1'b1;
    end
  end

  // One stimulus cycle; a ctl toggle exactly 4 cycles after the previous one is
  // pushed out by a cycle so captured data is always the word of its own toggle.
  task automatic drive(input bit do_ctl, input logic [3:0] a, input logic [31:0] c,
                       input bit do_sts, input logic [52:0] s);
    @(posedge pld_clk);
    #1;
    if (do_ctl && (cyc - last_ctl_tog == 4)) begin
      @(posedge pld_clk);
      #1;
    end
    if (do_ctl) begin
      if ((cyc - last_ctl_tog <= 3) && ctl_q.size() > 0) void'(ctl_q.pop_back());
      tl_cfg_add    = a;
      tl_cfg_ctl    = c;
      tl_cfg_ctl_wr = ~tl_cfg_ctl_wr;
      ctl_q.push_back('{due: cyc + 5, add: a, ctl: c});
      last_ctl_tog = cyc;
    end
    if (do_sts) begin
      tl_cfg_sts    = s;
      tl_cfg_sts_wr = ~tl_cfg_sts_wr;
      sts_q.push_back('{due: cyc + 1, sts: s});
      last_sts_exp = s;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge pld_clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    @(posedge pld_clk);
    #1;
    reset         = 1'b1;
    tl_cfg_ctl_wr = 1'b0;
    tl_cfg_sts_wr = 1'b0;
    ctl_q.delete();
    sts_q.delete();
    last_ctl_tog = -100;
    last_sts_exp = 53'h0;
    repeat (n) @(posedge pld_clk);
    #1;
    reset = 1'b0;
  endtask

  function automatic logic [52:0] new_sts();
    logic [52:0] s;
    s = {$urandom(), $urandom()};
    while (s == last_sts_exp || s == 53'h0) s = {$urandom(), $urandom()};
    return s;
  endfunction

  initial begin
    int r;
    int gap;
    do_reset(3);
    idle(2);

    // Bus/device capture
    drive(1, 4'hF, 32'h0000_0A25, 0, 53'h0);
    idle(6);
    chk("directed_busdev", cfg_busdev, 13'h0A25);
    chk("directed_seen", cfg_seen, 16'h8000);

    // Device control sub-fields
    drive(1, 4'h0, 32'h5030_0000, 0, 53'h0);
    idle(6);
    chk("directed_max_payload", cfg_max_payload, 3'd1);
    chk("directed_max_rd_req", cfg_max_rd_req, 3'd5);

    // Restart: second toggle one cycle into the settle window wins
    drive(1, 4'h3, 32'h1234_5678, 0, 53'h0);
    drive(1, 4'hC, 32'hFEE0_0000, 0, 53'h0);
    idle(7);
    chk("directed_msi_lo", cfg_msi_addr[31:0], 32'hFEE0_0000);

    // Simultaneous ctl and sts toggles
    drive(1, 4'h2, 32'hABCD_0000, 1, 53'h1F_0000_0000_0001);
    idle(7);
    chk("directed_sts", cfg_sts, 53'h1F_0000_0000_0001);
    chk("directed_link_ctrl", cfg_link_ctrl, 16'hABCD);

    // Reset while settling abandons the capture
    drive(1, 4'hF, 32'h0000_1111, 0, 53'h0);
    idle(1);
    do_reset(2);
    idle(8);
    chk("post_reset_ready", cfg_ready, 1'b0);

    // Required set captured in order 0, 2, 3, F
    drive(1, 4'h0, 32'h2010_0000, 0, 53'h0);
    idle(6);
    drive(1, 4'h2, 32'h0040_0000, 0, 53'h0);
    idle(6);
    drive(1, 4'h3, 32'h0000_0600, 0, 53'h0);
    idle(6);
    chk("ready_before_busdev", cfg_ready, 1'b0);
    drive(1, 4'hF, 32'h0000_0108, 0, 53'h0);
    idle(8);
    chk("ready_after_busdev", cfg_ready, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      if (r < 6) begin
        drive(1, 4'($urandom_range(0, 15)), $urandom(), 0, 53'h0);
      end else if (r < 8) begin
        drive(0, 4'h0, 32'h0, 1, new_sts());
      end else begin
        drive(1, 4'($urandom_range(0, 15)), $urandom(), 1, new_sts());
      end
      gap = $urandom_range(0, 7);
      if (gap > 0) idle(gap);
    end

    idle(12);
    chk("ctl_queue_drained", ctl_q.size(), 0);
    chk("sts_queue_drained", sts_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
